// File: rtl/cell_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : cell_sweep_checker
// Description : Exhaustive truth-table sequencer and checker for a
//               combinational standard cell. On START it drives every input
//               vector in ascending order. Each vector is held for SETTLE
//               cycles. At the end of each hold window the cell output is
//               compared with the EXPECT truth table. The block reports the
//               mismatch count, the first failing vector and a pass flag.
//
// Parameters  : N_IN    number of cell inputs (1..6)
//               EXPECT  expected truth table; bit i is ZN for vector i
//               SETTLE  hold cycles per vector (>= 1)
//
// Ports       : CK          clock, rising edge
//               RST         synchronous active-high reset
//               START       begin a sweep (accepted in IDLE only)
//               ZN_IN       output of the cell under test
//               VEC         vector driven to the cell (MSB -> A1)
//               VEC_VALID   high while VEC is being driven
//               BUSY        high while a sweep is in progress
//               DONE        one-cycle pulse at sweep completion
//               ERR_CNT     mismatching vectors in the last sweep
//               FIRST_FAIL  lowest mismatching vector index (0 if none)
//               FAIL        sticky; set on the first mismatch of a sweep
//               PASS        high after a completed sweep with no mismatch
//               CAPTURE     observed truth table (only when
//                           CELLSWEEP_CAPTURE_EN is defined)
//
// Optional    : CELLSWEEP_CAPTURE_EN adds the CAPTURE output and register.
//
// Revision    : 1.0  initial release
// ============================================================================
module cell_sweep_checker #(
  parameter int                  N_IN   = 4,
  parameter logic [2**N_IN-1:0]  EXPECT = 16'h0777,
  parameter int                  SETTLE = 10
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                START,
  input  logic                ZN_IN,
  output logic [N_IN-1:0]     VEC,
  output logic                VEC_VALID,
  output logic                BUSY,
  output logic                DONE,
  output logic [N_IN:0]       ERR_CNT,
  output logic [N_IN-1:0]     FIRST_FAIL,
  output logic                FAIL,
`ifdef CELLSWEEP_CAPTURE_EN
  output logic [2**N_IN-1:0]  CAPTURE,
`endif
  output logic                PASS
);

  // Settle counter only needs to reach SETTLE-1; keep at least one bit.
  localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   c_cnt_last  = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] c_vec_last  = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CW-1:0]     r_cnt;
  logic [N_IN-1:0]   r_vec;
  logic              r_vec_valid;
  logic              r_busy;
  logic [N_IN:0]     r_err_cnt;
  logic [N_IN-1:0]   r_first_fail;
  logic              r_fail;
  logic              r_pass;

  logic              w_start_acc;
  logic              w_sample;
  logic              w_done;
  logic              w_window_end;
  logic              w_last_vec;
  logic              w_mismatch;

  assign w_window_end = (r_cnt == c_cnt_last);
  assign w_last_vec   = (r_vec == c_vec_last);
  assign w_mismatch   = (ZN_IN != EXPECT[r_vec]);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_sample    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_sample = w_window_end;
        if (w_window_end && w_last_vec) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        // START is deliberately ignored here; a held START is taken
        // on the first IDLE cycle instead.
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sweep datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CK) begin
    if (RST) begin
      r_cnt        <= '0;
      r_vec        <= '0;
      r_vec_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_fail       <= 1'b0;
      r_pass       <= 1'b0;
    end else if (w_start_acc) begin
      r_cnt        <= '0;
      r_vec        <= '0;
      r_vec_valid  <= 1'b1;
      r_busy       <= 1'b1;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_fail       <= 1'b0;
      r_pass       <= 1'b0;
    end else if (r_state == S_HOLD) begin
      if (w_sample) begin
        if (w_mismatch) begin
          // Width N_IN+1 holds 2**N_IN, so this can never overflow.
          r_err_cnt <= r_err_cnt + (N_IN + 1)'(1);
          if (!r_fail) begin
            r_fail       <= 1'b1;
            r_first_fail <= r_vec;
          end
        end
        r_cnt <= '0;
        if (w_last_vec) begin
          // Terminate at the all-ones vector rather than wrapping.
          r_vec       <= '0;
          r_vec_valid <= 1'b0;
          r_busy      <= 1'b0;
        end else begin
          r_vec <= r_vec + N_IN'(1);
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (r_state == S_FIN) begin
      // ERR_CNT is final once FIN is entered, so PASS is taken from it here.
      r_pass <= (r_err_cnt == '0);
    end
  end

`ifdef CELLSWEEP_CAPTURE_EN
  logic [2**N_IN-1:0] r_capture;

  always_ff @(posedge CK) begin
    if (RST) begin
      r_capture <= '0;
    end else if (w_start_acc) begin
      r_capture <= '0;
    end else if (w_sample) begin
      r_capture[r_vec] <= ZN_IN;
    end
  end

  assign CAPTURE = r_capture;
`endif

  assign VEC        = r_vec;
  assign VEC_VALID  = r_vec_valid;
  assign BUSY       = r_busy;
  assign DONE       = w_done;
  assign ERR_CNT    = r_err_cnt;
  assign FIRST_FAIL = r_first_fail;
  assign FAIL       = r_fail;
  assign PASS       = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_cell_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_sweep_checker
// Description : Directed self-checking bench for cell_sweep_checker with the
//               default AOI22 configuration (N_IN=4, EXPECT=16'h0777,
//               SETTLE=10). A behavioural cell model drives ZN_IN as an ideal
//               AOI22, stuck-at-0 or stuck-at-1.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cell_sweep_checker;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ZN_IN;
  logic [3:0] VEC;
  logic       VEC_VALID;
  logic       BUSY;
  logic       DONE;
  logic [4:0] ERR_CNT;
  logic [3:0] FIRST_FAIL;
  logic       FAIL;
  logic       PASS;
`ifdef CELLSWEEP_CAPTURE_EN
  logic [15:0] CAPTURE;
`endif

  int checks = 0;
  int errors = 0;

  // 0: ideal AOI22, 1: stuck at 0, 2: stuck at 1
  int mode = 0;

  // A1=VEC[3], A2=VEC[2], B1=VEC[1], B2=VEC[0]
  assign ZN_IN = (mode == 1) ? 1'b0 :
                 (mode == 2) ? 1'b1 :
                 ~((VEC[3] & VEC[2]) | (VEC[1] & VEC[0]));

  cell_sweep_checker #(
    .N_IN   (4),
    .EXPECT (16'h0777),
    .SETTLE (10)
  ) dut (
    .CK         (CK),
    .RST        (RST),
    .START      (START),
    .ZN_IN      (ZN_IN),
    .VEC        (VEC),
    .VEC_VALID  (VEC_VALID),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR_CNT    (ERR_CNT),
    .FIRST_FAIL (FIRST_FAIL),
    .FAIL       (FAIL),
`ifdef CELLSWEEP_CAPTURE_EN
    .CAPTURE    (CAPTURE),
`endif
    .PASS       (PASS)
  );

  always #5 CK = ~CK;

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // Pulse START, then follow the sweep until DONE. Returns the number of
  // BUSY cycles, whether DONE was seen, and whether VEC followed k = cycle/10.
  task automatic run_sweep(output int busy_n, output bit done_ok, output bit vec_ok);
    START = 1'b1;
    step();
    START = 1'b0;
    busy_n  = 0;
    done_ok = 1'b0;
    vec_ok  = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (DONE) begin
        done_ok = 1'b1;
        break;
      end
      if (BUSY) begin
        if (VEC !== 4'(busy_n / 10) || VEC_VALID !== 1'b1) vec_ok = 1'b0;
        busy_n++;
      end
      step();
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({VEC, VEC_VALID, BUSY, DONE, ERR_CNT, FIRST_FAIL, FAIL, PASS} !== 16'h0) begin
      errors++;
      $display("FAIL %s: VEC=%0d VALID=%b BUSY=%b DONE=%b ERR=%0d FF=%0d FAIL=%b PASS=%b, required all 0",
               name, VEC, VEC_VALID, BUSY, DONE, ERR_CNT, FIRST_FAIL, FAIL, PASS);
    end
`ifdef CELLSWEEP_CAPTURE_EN
    checks++;
    if (CAPTURE !== 16'h0) begin
      errors++;
      $display("FAIL %s_capture: got %h, required 0000", name, CAPTURE);
    end
`endif
  endtask

  // Common checks for a completed sweep, done at the DONE cycle and the one after.
  task automatic check_sweep(input string name, input int busy_n, input bit done_ok,
                             input bit vec_ok, input logic [4:0] exp_err,
                             input logic [3:0] exp_ff, input logic exp_fail,
                             input logic exp_pass, input logic [15:0] exp_cap);
    checks++;
    if (!done_ok) begin
      errors++;
      $display("FAIL %s_done: DONE not seen within 400 cycles, required DONE pulse", name);
    end
    checks++;
    if (busy_n !== 160) begin
      errors++;
      $display("FAIL %s_busy: BUSY cycles %0d, required 160", name, busy_n);
    end
    checks++;
    if (!vec_ok) begin
      errors++;
      $display("FAIL %s_vecseq: VEC sequence wrong, required k held for 10 cycles", name);
    end
    checks++;
    if (ERR_CNT !== exp_err || FIRST_FAIL !== exp_ff || FAIL !== exp_fail) begin
      errors++;
      $display("FAIL %s_result: ERR=%0d FF=%0d FAIL=%b, required ERR=%0d FF=%0d FAIL=%b",
               name, ERR_CNT, FIRST_FAIL, FAIL, exp_err, exp_ff, exp_fail);
    end
`ifdef CELLSWEEP_CAPTURE_EN
    checks++;
    if (CAPTURE !== exp_cap) begin
      errors++;
      $display("FAIL %s_capture: got %h, required %h", name, CAPTURE, exp_cap);
    end
`else
    if (exp_cap === 16'hxxxx) $display("unreachable");
`endif
    step();
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || PASS !== exp_pass) begin
      errors++;
      $display("FAIL %s_pass: DONE=%b BUSY=%b PASS=%b, required DONE=0 BUSY=0 PASS=%b",
               name, DONE, BUSY, PASS, exp_pass);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    RST = 1'b0;
    step();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_ideal();
    int b; bit d; bit v;
    mode = 0;
    run_sweep(b, d, v);
    check_sweep("ideal", b, d, v, 5'd0, 4'd0, 1'b0, 1'b1, 16'h0777);
  endtask

  task automatic test_stuck0();
    int b; bit d; bit v;
    mode = 1;
    run_sweep(b, d, v);
    check_sweep("stuck0", b, d, v, 5'd9, 4'd0, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic test_stuck1();
    int b; bit d; bit v;
    mode = 2;
    run_sweep(b, d, v);
    check_sweep("stuck1", b, d, v, 5'd7, 4'd3, 1'b1, 1'b0, 16'hFFFF);
  endtask

  task automatic test_reset_mid_sweep();
    int b; bit d; bit v;
    bit reached = 1'b0;
    mode = 2;  // vector 3 mismatches, so partial results are non-zero by VEC=5
    START = 1'b1;
    step();
    START = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (VEC == 4'd5) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!reached || ERR_CNT !== 5'd1 || FAIL !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: reached=%b ERR=%0d FAIL=%b, required reached=1 ERR=1 FAIL=1",
               reached, ERR_CNT, FAIL);
    end
    RST = 1'b1;
    step();
    check_all_zero("midreset");
    RST = 1'b0;
    repeat (20) step();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: BUSY=%b DONE=%b, required 0 0", BUSY, DONE);
    end
    mode = 0;
    run_sweep(b, d, v);
    check_sweep("after_reset", b, d, v, 5'd0, 4'd0, 1'b0, 1'b1, 16'h0777);
  endtask

  task automatic test_back_to_back();
    int busy_n = 0;
    int dones  = 0;
    int done_c = -1;
    bit found  = 1'b0;
    mode = 0;
    START = 1'b1;
    step();
    START = 1'b0;
    // Sample c is taken 1 time unit after edge E0+c.
    for (int c = 0; c <= 170; c++) begin
      if (c < 160 && BUSY) busy_n++;
      if (DONE) begin
        dones++;
        done_c = c;
      end
      if (c == 161) begin
        checks++;
        if (BUSY !== 1'b0 || PASS !== 1'b1) begin
          errors++;
          $display("FAIL b2b_fin_ignore: BUSY=%b PASS=%b, required BUSY=0 PASS=1", BUSY, PASS);
        end
      end
      if (c == 162) begin
        checks++;
        if (BUSY !== 1'b1 || VEC !== 4'd0 || VEC_VALID !== 1'b1 || PASS !== 1'b0) begin
          errors++;
          $display("FAIL b2b_restart: BUSY=%b VEC=%0d VALID=%b PASS=%b, required 1 0 1 0",
                   BUSY, VEC, VEC_VALID, PASS);
        end
        START = 1'b0;
      end
      if (c == 39) START = 1'b1;   // seen by edge E0+40, mid-sweep
      if (c == 40) START = 1'b0;
      if (c == 159) START = 1'b1;  // held through FIN into IDLE
      step();
    end
    checks++;
    if (dones !== 1 || done_c !== 160 || busy_n !== 160) begin
      errors++;
      $display("FAIL b2b_single_done: dones=%0d at %0d busy=%0d, required 1 at 160 busy=160",
               dones, done_c, busy_n);
    end
    for (int c = 0; c < 400; c++) begin
      if (DONE) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found || ERR_CNT !== 5'd0 || FAIL !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: found=%b ERR=%0d FAIL=%b, required 1 0 0", found, ERR_CNT, FAIL);
    end
    step();
    checks++;
    if (PASS !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_pass: PASS=%b, required 1", PASS);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ideal();
    test_stuck0();
    test_stuck1();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cell_sweep_checker.md
# cell_sweep_checker

Exhaustive truth-table stimulus sequencer and checker for combinational standard cells such as AOI22_X4. It sits directly upstream of the cell under test and consumes the cell's output. On START it drives every input vector in ascending order and holds each one for a settle window. It samples the cell output at the end of each window, compares it against a parameterised expected truth table, and reports the mismatch count, the first failing vector and a pass flag. It is synthesizable and replaces hand-written per-cell `$display` sweeps in both silicon self-test and simulation.

## Interface
- N_IN, 4: number of cell inputs; legal range 1–6.
- EXPECT, 16'h0777: expected output truth table, width 2^N_IN. Bit i is the expected ZN for input vector i. The default is AOI22 with {A1,A2,B1,B2} = VEC[3:0].
- SETTLE, 10: cycles each vector is held before sampling; must be ≥1.

- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- START  in  1  begin a sweep; accepted only in IDLE.
- ZN_IN  in  1  output of the cell under test.
- VEC  out  N_IN  input vector driven to the cell; MSB to A1.
- VEC_VALID  out  1  high while VEC is being driven.
- BUSY  out  1  high while a sweep is in progress.
- DONE  out  1  one-cycle pulse when a sweep completes.
- ERR_CNT  out  N_IN+1  number of mismatching vectors in the last sweep.
- FIRST_FAIL  out  N_IN  index of the lowest-numbered mismatching vector; 0 if there are no mismatches.
- FAIL  out  1  sticky; set on the first mismatch of a sweep.
- PASS  out  1  high after a completed sweep with ERR_CNT==0.

## Operation
- States: IDLE, HOLD, FIN.
- **IDLE**
  - All of VEC, VEC_VALID, BUSY, DONE, ERR_CNT, FIRST_FAIL, FAIL and PASS are 0 after reset.
  - Result outputs keep their last-sweep values until the next START.
- **IDLE → HOLD** when START=1:
  - VEC←0, VEC_VALID←1, BUSY←1, settle counter←0.
  - ERR_CNT, FIRST_FAIL, FAIL and PASS are cleared.
- **HOLD**
  - The settle counter increments each cycle.
  - On the edge where the counter reaches SETTLE-1, ZN_IN is compared with EXPECT[VEC].
  - On a mismatch, ERR_CNT increments. If FAIL was 0, FAIL←1 and FIRST_FAIL←VEC.
  - If VEC < 2^N_IN-1: VEC←VEC+1, counter←0, stay in HOLD.
  - Otherwise: go to FIN with VEC_VALID←0, BUSY←0, VEC←0.
- **FIN** (one cycle): DONE=1 and PASS=(ERR_CNT==0), then return to IDLE.
- START is ignored in HOLD and FIN; a START held high in FIN is not accepted until IDLE.
- VEC does not wrap: the sweep terminates at the all-ones vector, and the counter never exceeds 2^N_IN-1.
- ERR_CNT saturation is impossible, because its width N_IN+1 holds 2^N_IN.
- RST has priority over every transition. Asserting it mid-sweep returns the block to IDLE with all outputs 0 on the same edge; no partial results are kept.

## Timing
- START sampled at edge E0: VEC=0 and BUSY=1 from E0.
- Vector k is driven during cycles [E0+k·SETTLE, E0+(k+1)·SETTLE).
- ZN_IN is sampled at the edge E0+(k+1)·SETTLE; results update on that edge.
- BUSY stays high for exactly 2^N_IN·SETTLE cycles; with the defaults this is 160.
- DONE is high in the single cycle starting at edge E0+2^N_IN·SETTLE. PASS becomes valid on the edge after that.
- Cell propagation delay must be less than SETTLE cycles. The block adds no input synchroniser on ZN_IN.

## Configuration
- **CELLSWEEP_CAPTURE_EN defined:**
  - Adds output CAPTURE, out, width 2^N_IN, reset 0, cleared on START acceptance.
  - At each sample edge, CAPTURE[VEC]←ZN_IN, so after DONE it holds the observed truth table.
  - Adds one 2^N_IN-bit register.
- **CELLSWEEP_CAPTURE_EN undefined:**
  - The CAPTURE port and register do not exist.
  - All other behaviour is identical.

## Test plan
- Ideal AOI22 model on VEC/ZN_IN, defaults, START pulse → BUSY for 160 cycles, DONE pulse, ERR_CNT=0, FAIL=0, FIRST_FAIL=0, PASS=1.
- ZN_IN stuck at 0 → ERR_CNT=9, FIRST_FAIL=0, FAIL=1, PASS=0.
- ZN_IN stuck at 1 → ERR_CNT=7, FIRST_FAIL=3, PASS=0.
- RST asserted while VEC=5 → next edge: all outputs 0, state IDLE. A following START gives a full 160-cycle sweep from VEC=0.
- START re-pulsed at cycle 40 of a sweep, and held high through FIN → ignored; exactly one DONE. A new sweep starts only at the first IDLE cycle with START=1.
- With CELLSWEEP_CAPTURE_EN and the ideal model → CAPTURE=16'h0777 at DONE. With ZN_IN stuck at 1 → CAPTURE=16'hFFFF.
